// File: rtl/lut_layer_pkg.sv
// Shared types, defaults and helpers for the runtime-loadable LUT layer.
package lut_layer_pkg;

    localparam int DEF_NEURONS  = 4;
    localparam int DEF_IN_BITS  = 8;
    localparam int DEF_OUT_BITS = 2;

    typedef enum logic {
        INIT,
        RUN
    } lut_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/lut_layer_rt_neuron_ram.sv
// One neuron's truth table: synchronous write, asynchronous read, mapped to distributed RAM.
module lut_neuron_ram
    import lut_layer_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IN_BITS-1:0]  waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
);

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [OUT_BITS-1:0] mem_q [2**IN_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lut_layer_rt.sv
// Layer of runtime-programmable LUT neurons: clears its tables after reset, then
// serves table writes and registered lookups behind valid/ready handshakes.
module lut_layer_rt
    import lut_layer_pkg::*;
#(
    parameter int NEURONS  = DEF_NEURONS,
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS,
    parameter int NIDX_W   = (clog2(NEURONS) > 1) ? clog2(NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [NIDX_W-1:0]            cfg_neuron,
    input  logic [IN_BITS-1:0]           cfg_addr,
    input  logic [OUT_BITS-1:0]          cfg_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NEURONS*IN_BITS-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NEURONS*OUT_BITS-1:0]  out_data,
    output logic                         busy
);

    lut_state_t                    state_q, state_d;
    logic [IN_BITS-1:0]            clr_addr_q, clr_addr_d;
    logic                          out_valid_q, out_valid_d;
    logic [NEURONS*OUT_BITS-1:0]   out_data_q, out_data_d;
    logic [NEURONS*OUT_BITS-1:0]   lookup;
    logic                          in_init;
    logic                          cfg_fire;
    logic                          in_fire;

    assign in_init   = (state_q == INIT);
    assign busy      = in_init;
    assign cfg_ready = !in_init;
    assign in_ready  = !in_init && !cfg_valid && (!out_valid_q || out_ready);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == INIT) begin
            clr_addr_d = clr_addr_q + IN_BITS'(1);
            if (clr_addr_q == '1) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = lookup;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= INIT;
            clr_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Writes are suppressed on a reset edge so no half-accepted config lands in a table.
    generate
        for (genvar gi = 0; gi < NEURONS; gi++) begin : g_neuron
            logic                we;
            logic [IN_BITS-1:0]  waddr;
            logic [OUT_BITS-1:0] wdata;

            assign we    = rst && (in_init || (cfg_fire && (cfg_neuron == NIDX_W'(gi))));
            assign waddr = in_init ? clr_addr_q : cfg_addr;
            assign wdata = in_init ? '0 : cfg_data;

            lut_neuron_ram #(
                .IN_BITS  (IN_BITS),
                .OUT_BITS (OUT_BITS)
            ) u_ram (
                .clk   (clk),
                .we    (we),
                .waddr (waddr),
                .wdata (wdata),
                .raddr (in_data[gi*IN_BITS +: IN_BITS]),
                .rdata (lookup[gi*OUT_BITS +: OUT_BITS])
            );
        end
    endgenerate

endmodule

// File: tb/tb_lut_layer_rt.sv
// Scoreboard bench for lut_layer_rt: random table writes and lookups against a table model.
module tb_lut_layer_rt;
    import lut_layer_pkg::*;

    localparam int N  = 4;
    localparam int IB = 8;
    localparam int OB = 2;
    localparam int NW = 3;

    logic              clk;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [NW-1:0]     cfg_neuron;
    logic [IB-1:0]     cfg_addr;
    logic [OB-1:0]     cfg_data;
    logic              in_valid;
    logic              in_ready;
    logic [N*IB-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N*OB-1:0]   out_data;
    logic              busy;

    logic [OB-1:0]     model [N][256];
    logic [N*OB-1:0]   exp_q [$];
    int                total = 0;
    int                bad   = 0;
    bit                bp_mode = 0;

    lut_layer_rt #(
        .NEURONS  (N),
        .IN_BITS  (IB),
        .OUT_BITS (OB),
        .NIDX_W   (NW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    function automatic logic [N*OB-1:0] predict(input logic [N*IB-1:0] d);
        logic [N*OB-1:0] r;
        r = '0;
        for (int n = 0; n < N; n++) begin
            r[n*OB +: OB] = model[n][d[n*IB +: IB]];
        end
        return r;
    endfunction

    function automatic void clear_model();
        for (int n = 0; n < N; n++) begin
            for (int a = 0; a < 256; a++) begin
                model[n][a] = '0;
            end
        end
    endfunction

    function automatic logic [N*IB-1:0] small_vec();
        logic [N*IB-1:0] v;
        for (int n = 0; n < N; n++) begin
            v[n*IB +: IB] = IB'($urandom_range(0, 15));
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int n, input int a, input int d);
        int k;
        cfg_valid  = 1'b1;
        cfg_neuron = NW'(n);
        cfg_addr   = IB'(a);
        cfg_data   = OB'(d);
        k = 0;
        @(negedge clk);
        while (!cfg_ready && k < 1000) begin
            k++;
            @(negedge clk);
        end
        if (!cfg_ready) begin
            check("cfg_accept_timeout", 64'(cfg_ready), 64'd1);
        end else if (n < N) begin
            model[n][a] = OB'(d);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [N*IB-1:0] d);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 1000) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("in_accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            exp_q.push_back(predict(d));
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        check("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic count_init(input string name);
        int cnt;
        cnt = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check(name, 64'(cnt), 64'd256);
        check("cfg_ready_after_init", 64'(cfg_ready), 64'd1);
    endtask

    // Downstream readiness: always ready, or a repeating 1,0,0,1 pattern.
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                ph++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: compares each transferred result and checks stability while stalled.
    initial begin
        logic            stalled;
        logic [N*OB-1:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst && stalled) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(held));
            end
            stalled = rst && out_valid && !out_ready;
            held    = out_data;
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 64'(out_valid), 64'd0);
                end else begin
                    check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [N*IB-1:0] v;
        rst        = 1'b0;
        cfg_valid  = 1'b0;
        cfg_neuron = '0;
        cfg_addr   = '0;
        cfg_data   = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        clear_model();

        // Reset state, with a write held across reset and INIT
        tick();
        tick();
        cfg_valid  = 1'b1;
        cfg_neuron = NW'(1);
        cfg_addr   = IB'(3);
        cfg_data   = OB'(2);
        in_valid   = 1'b1;
        tick();
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        count_init("init_cycles");
        model[1][3] = 2'd2;
        tick();
        cfg_valid = 1'b0;
        in_valid  = 1'b0;

        // Cleared tables
        send('1);
        send('0);
        for (int i = 0; i < 4; i++) begin
            send($urandom());
        end
        send(32'h0303_0303);
        drain();

        // Program and lookup
        cfg_write(2, 8'hA5, 3);
        send(32'h00A5_0000);
        drain();

        // Write priority over a simultaneous input
        v = $urandom();
        v[7:0] = 8'h11;
        cfg_valid  = 1'b1;
        cfg_neuron = NW'(0);
        cfg_addr   = 8'h11;
        cfg_data   = 2'd1;
        in_valid   = 1'b1;
        in_data    = v;
        @(negedge clk);
        check("prio_in_ready_low", 64'(in_ready), 64'd0);
        model[0][8'h11] = 2'd1;
        tick();
        cfg_valid = 1'b0;
        @(negedge clk);
        check("prio_in_ready_high", 64'(in_ready), 64'd1);
        exp_q.push_back(predict(v));
        tick();
        in_valid = 1'b0;
        drain();

        // Out-of-range neuron index
        cfg_write(5, 8'h5C, 3);
        send(32'h5C5C_5C5C);
        drain();

        // Random writes and lookups on a small address range
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                cfg_write($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3));
            end else begin
                send(small_vec());
            end
        end
        drain();

        // Backpressure
        bp_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(small_vec());
        end
        drain();
        bp_mode = 1'b0;
        tick();

        // Mid-operation reset with a result in flight
        send(small_vec());
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        clear_model();
        count_init("reinit_cycles");
        tick();
        for (int a = 0; a < 256; a++) begin
            v = {N{8'(a)}};
            send(v);
        end
        drain();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
